display_scan_controller: RTL
============================

// Module: display_scan_controller
// PURPOSE
//  Time-multiplexes the six 5-bit digit codes from the display option controller onto one shared
//  7-segment bus. Each digit owns one time slot, and the slots are scanned in a fixed rotation.
//  New codes are taken only at frame boundaries, so a frame never shows a mix of old and new codes.
//  The block also provides PWM brightness, anti-ghost dead time and a frame-sync strobe.
//  It sits between the display option controller and the board's segment and digit pins.
// PARAMETERS
//  CLK_DIV   50000  clock cycles per digit slot (>= DEAD_CYC+8)
//  DEAD_CYC  64     cycles at the start of each slot with all digits off
// PORTS
//  CLK         in   1  system clock, rising edge
//  RST         in   1  reset, asynchronous, active-high
//  D1..D6      in   5  digit codes; D1 is the rightmost digit
//  UPDATE      in   1  one-cycle strobe: capture D1..D6
//  BRIGHT      in   3  brightness 0 (dimmest) .. 7 (full)
//  SEG_N       out  8  {dp,g,f,e,d,c,b,a}, active-low
//  DIG_N       out  6  digit enables, active-low; bit0 = D1
//  FRAME_SYNC  out  1  one-cycle pulse when a new frame starts (idx 5->0)
// BEHAVIOUR
//  - Reset (async, RST high):
//      cnt=0, idx=0, pending=0.
//      Staging and active code banks all = 5'b10001 (dash).
//      Active BRIGHT = 7.
//      DIG_N=6'h3F, SEG_N=8'hFF, FRAME_SYNC=0, all immediately.
//    Reset mid-scan aborts the slot. The first slot after release is idx0.
//  - Prescaler: cnt counts 0..CLK_DIV-1 and wraps. tick = (cnt==CLK_DIV-1).
//  - Slot index: on tick, idx advances 0->1->...->5->0.
//  - Frame boundary = tick while idx==5. At the boundary:
//      staging -> active codes, but only if pending.
//      BRIGHT -> active brightness.
//      pending cleared.
//  - UPDATE handling:
//      UPDATE loads staging from D1..D6 and sets pending. The last UPDATE before a boundary wins.
//      UPDATE in the same cycle as the boundary: active bank loads D1..D6 directly and pending stays 0.
//  - On-window within a slot:
//      on = (cnt >= DEAD_CYC) && ((cnt-DEAD_CYC)*8 < (CLK_DIV-DEAD_CYC)*(BRIGHT_act+1)).
//      Evaluate in 32-bit unsigned arithmetic.
//      BRIGHT=7 keeps the digit on for the entire post-dead-time window.
//  - Outputs are registered and lag (cnt, idx) by one cycle:
//      DIG_N = on ? ~(6'b1 << idx) : 6'h3F.
//      SEG_N = on ? decode(active[idx]) : 8'hFF.
//    DIG_N never has more than one bit low.
//  - FRAME_SYNC is registered and high for exactly the one cycle after the boundary tick.
//  - Decode table (active-low {dp,g..a}, dp always off):
//      0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8
//      8:80 9:90 A:88 b:83 C:C6 d:A1 E:86 F:8E
//      10000 blank:FF   10001 dash:BF   10010..11111: FF
// STRUCTURE
//  - Shared package holds:
//      CODE_BLANK=5'b10000, CODE_DASH=5'b10001.
//      The 18-entry glyph table, SEG_OFF=8'hFF, DIG_OFF=6'h3F.
//  - One combinational sub-module, seg_decode (5-bit code -> 8-bit SEG_N), instanced once on the
//    muxed active code.
//  - Top level holds the prescaler, slot ring, the two code banks, brightness compare and output
//    registers.
// TESTING  (bench uses CLK_DIV=16, DEAD_CYC=2)
//  - Reset: assert RST mid-slot -> DIG_N=3F and SEG_N=FF in the same cycle.
//    After release, every slot shows SEG_N=BF (dash).
//  - Scan order: BRIGHT=7, D1..D6=1..6, UPDATE, wait one boundary. Each slot is 16 cycles:
//      DIG_N sequence 3E,3D,3B,37,2F,1F.
//      SEG_N F9,A4,B0,99,92,82.
//      2 dead cycles per slot with DIG_N=3F.
//  - Tear-free: UPDATE with D1..D6=A..F during idx2 -> idx3..5 still show 4..6.
//    FRAME_SYNC pulses once, then idx0 shows 88.
//  - Brightness: BRIGHT=3 -> 7 on-cycles per slot (cnt 2..8).
//    BRIGHT=0 -> 2 on-cycles (cnt 2..3).
//    A BRIGHT change mid-frame takes effect only in the next frame.
//  - Decode: D1 = 10000 / 10001 / 10101 / 01011 -> SEG_N FF / BF / FF / 83.
//  - Coincident UPDATE with the boundary tick -> new D1 glyph shown in the very next idx0 slot,
//    and pending=0.

Source files
------------

// File: rtl/display_scan_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : display_scan_controller_pkg
//  Description : Shared code points, glyph table and idle levels for the
//                multiplexed 7-segment display scanner.
//  Revision    : 1.0 - initial release
// ============================================================================
package display_scan_controller_pkg;

    localparam logic [4:0] CODE_BLANK = 5'b10000;
    localparam logic [4:0] CODE_DASH  = 5'b10001;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [5:0] DIG_OFF = 6'h3F;

    localparam int NUM_GLYPHS = 18;

    // Active-low {dp,g,f,e,d,c,b,a}; hex digits 0..F, then blank and dash.
    localparam logic [7:0] GLYPH_TABLE [NUM_GLYPHS] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E,
        8'hFF, 8'hBF
    };

endpackage : display_scan_controller_pkg
`default_nettype wire

// File: rtl/display_scan_controller_seg_decode.sv
`default_nettype none
// ============================================================================
//  Module      : display_scan_controller_seg_decode
//  Description : Combinational 5-bit digit code to active-low segment decode.
//  Revision    : 1.0 - initial release
// ============================================================================
module display_scan_controller_seg_decode
    import display_scan_controller_pkg::*;
(
    input  logic [4:0] i_code,
    output logic [7:0] o_seg_n
);

    always_comb begin
        o_seg_n = SEG_OFF;
        if (i_code < 5'(NUM_GLYPHS)) begin
            o_seg_n = GLYPH_TABLE[i_code];
        end
    end

endmodule : display_scan_controller_seg_decode
`default_nettype wire

// File: rtl/display_scan_controller.sv
`default_nettype none
// ============================================================================
//  Module      : display_scan_controller
//  Description : Six-digit 7-segment scanner with frame-boundary code update,
//                PWM brightness, anti-ghost dead time and frame-sync strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module display_scan_controller
    import display_scan_controller_pkg::*;
#(
    parameter int CLK_DIV  = 50000,
    parameter int DEAD_CYC = 64
)
(
    input  logic       CLK,
    input  logic       RST,
    input  logic [4:0] D1,
    input  logic [4:0] D2,
    input  logic [4:0] D3,
    input  logic [4:0] D4,
    input  logic [4:0] D5,
    input  logic [4:0] D6,
    input  logic       UPDATE,
    input  logic [2:0] BRIGHT,
    output logic [7:0] SEG_N,
    output logic [5:0] DIG_N,
    output logic       FRAME_SYNC
);

    localparam int               CNT_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [2:0]       C_LAST_IDX = 3'd5;
    localparam logic [31:0]      C_DEAD     = 32'(DEAD_CYC);
    localparam logic [31:0]      C_WINDOW   = 32'(CLK_DIV - DEAD_CYC);

    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic             r_pending;
    logic [5:0][4:0]  r_stage;
    logic [5:0][4:0]  r_active;
    logic [2:0]       r_bright;
    logic [7:0]       r_seg_n;
    logic [5:0]       r_dig_n;
    logic             r_frame_sync;

    logic [5:0][4:0]  w_din;
    logic             w_tick;
    logic             w_boundary;
    logic [31:0]      w_cnt32;
    logic             w_on;
    logic [4:0]       w_code;
    logic [7:0]       w_seg_n;

    assign w_din      = {D6, D5, D4, D3, D2, D1};
    assign w_tick     = (r_cnt == C_CNT_LAST);
    assign w_boundary = w_tick && (r_idx == C_LAST_IDX);

    // Bright level b lights (b+1)/8 of the post-dead-time part of the slot.
    assign w_cnt32 = 32'(r_cnt);
    assign w_on    = (w_cnt32 >= C_DEAD) &&
                     (((w_cnt32 - C_DEAD) << 3) < (C_WINDOW * (32'(r_bright) + 32'd1)));

    assign w_code = (r_idx <= C_LAST_IDX) ? r_active[r_idx] : CODE_BLANK;

    display_scan_controller_seg_decode u_seg_decode (
        .i_code  (w_code),
        .o_seg_n (w_seg_n)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
            r_idx <= (r_idx == C_LAST_IDX) ? 3'd0 : r_idx + 3'd1;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // A strobe coinciding with the boundary bypasses staging so it is not lost.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_pending <= 1'b0;
            r_stage   <= {6{CODE_DASH}};
            r_active  <= {6{CODE_DASH}};
            r_bright  <= 3'd7;
        end else begin
            if (UPDATE) begin
                r_stage <= w_din;
            end
            if (w_boundary) begin
                r_pending <= 1'b0;
                r_bright  <= BRIGHT;
                if (UPDATE) begin
                    r_active <= w_din;
                end else if (r_pending) begin
                    r_active <= r_stage;
                end
            end else if (UPDATE) begin
                r_pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_dig_n      <= DIG_OFF;
            r_seg_n      <= SEG_OFF;
            r_frame_sync <= 1'b0;
        end else begin
            r_dig_n      <= w_on ? ~(6'b1 << r_idx) : DIG_OFF;
            r_seg_n      <= w_on ? w_seg_n : SEG_OFF;
            r_frame_sync <= w_boundary;
        end
    end

    assign SEG_N      = r_seg_n;
    assign DIG_N      = r_dig_n;
    assign FRAME_SYNC = r_frame_sync;

endmodule : display_scan_controller
`default_nettype wire
